nn_inst_sequencer: RTL and testbench
====================================

// Module: nn_inst_sequencer
// PURPOSE
//  Upstream stage of the NeuralNetwork controller. Fetches instruction words from the
//  instruction memory, decodes them and issues opcode, lengths and XY/W addresses to
//  the controller with a valid/ready handshake. Waits for completion before fetching
//  the next word. Replaces the bench-forced controller inputs in the integrated design.
// PARAMETERS
//  PC_W         8   instruction memory address width (2**PC_W words)
//  XY_MEM_DEPTH 8   XY memory address width
//  W_MEM_DEPTH  10  W memory address width
//  MOV_LENGTH   8   width of length0/length1
//  OPC_W        4   opcode width; INST_W = OPC_W+2*XY_MEM_DEPTH+W_MEM_DEPTH+2*MOV_LENGTH
// PORTS
//  clk           in   1       clock, rising edge
//  reset_n       in   1       asynchronous reset, active low
//  start         in   1       begin execution at start_pc; sampled only in IDLE/HALTED
//  start_pc      in   PC_W    first instruction address
//  abort         in   1       return to IDLE from any state
//  imem_rd_en    out  1       instruction memory read strobe
//  imem_addr     out  PC_W    instruction memory address (= pc)
//  imem_rdata    in   INST_W  read data, valid 1 cycle after imem_rd_en
//  issue_valid   out  1       issued fields below are valid
//  ctrl_ready    in   1       controller accepts the issued instruction
//  ctrl_done     in   1       1-cycle pulse: controller finished the instruction
//  instruction   out  OPC_W   opcode to controller
//  length0       out  MOV_LENGTH   first length field
//  length1       out  MOV_LENGTH   second length field
//  xy_read_addr  out  XY_MEM_DEPTH  X base address
//  xy_write_addr out  XY_MEM_DEPTH  Y base address
//  w_read_addr   out  W_MEM_DEPTH   W base address
//  busy          out  1       state not IDLE/HALTED
//  halted        out  1       HALT executed or illegal opcode seen
//  err_illegal   out  1       sticky: illegal opcode decoded; cleared by start
// BEHAVIOUR
//  Word layout MSB->LSB: {opcode, x_addr, y_addr, w_addr, length0, length1}.
//  Opcodes: INST_HALT, INST_FORWARD, INST_NOP; any other value is illegal.
//  Reset: state IDLE, pc=0, all outputs 0 except instruction=INST_HALT.
//  FSM: IDLE -start-> FETCH (pc<=start_pc). FETCH: imem_rd_en=1 -> DECODE.
//   DECODE: latch fields from imem_rdata; HALT -> HALTED; illegal -> HALTED + err_illegal;
//   NOP, or FORWARD with length0+length1==0 -> pc++, FETCH (nothing issued);
//   FORWARD otherwise -> ISSUE.
//   ISSUE: issue_valid=1, fields held stable; valid&&ctrl_ready -> WAIT.
//   WAIT: issue_valid=0, fields held; ctrl_done -> pc++, FETCH.
//   HALTED: halted=1, pc holds HALT address; start -> FETCH at start_pc, clears flags.
//  Latency: start at edge N -> imem_rd_en cycle N+1 -> issue_valid cycle N+3;
//   ctrl_done at cycle M -> next imem_rd_en cycle M+1.
//  ctrl_done ignored outside WAIT; controller never pulses done in its accept cycle.
//  start ignored while busy. pc increments modulo 2**PC_W (wraps to 0).
//  abort: next cycle IDLE, issue_valid=0, instruction=INST_HALT; abort wins over start.
//  Async reset mid-operation: same as power-on reset, no partial issue persists.
// STRUCTURE
//  definitions package: opcode constants (add INST_NOP), inst_t packed struct for the
//   word layout, seq_state_t enum. One module, no sub-modules; decode is a function.
// TESTING
//  1 mem[0]=FORWARD(x2,y0,w12,l0=4,l1=2), mem[1]=HALT; start_pc=0, ready=1, done 6
//    cycles after accept -> issue_valid cycle 3 with fields 2/0/12/4/2, then halted=1, pc=1.
//  2 Same program, ctrl_ready low 5 cycles -> issue_valid and all fields stable 5 cycles,
//    accepted on cycle ready rises; exactly one accept.
//  3 mem[0]=FORWARD l0=0,l1=0, mem[1]=NOP, mem[2]=HALT -> no issue_valid ever; halted, pc=2.
//  4 start_pc=255: mem[255]=FORWARD, mem[0]=HALT -> imem_addr 255 then 0; halted, pc=0.
//  5 mem[0]=opcode 4'hF -> err_illegal=1, halted=1, no issue; new start clears both.
//  6 reset_n low during WAIT, then abort during ISSUE on rerun -> outputs at reset values,
//    issue_valid=0 next cycle, state IDLE; later ctrl_done pulses ignored.

Source files
------------

// File: rtl/nn_inst_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, word layout and FSM states.
package nn_inst_sequencer_pkg;

  localparam int PC_W         = 8;
  localparam int XY_MEM_DEPTH = 8;
  localparam int W_MEM_DEPTH  = 10;
  localparam int MOV_LENGTH   = 8;
  localparam int OPC_W        = 4;
  localparam int INST_W       = OPC_W + 2*XY_MEM_DEPTH + W_MEM_DEPTH + 2*MOV_LENGTH;

  localparam logic [OPC_W-1:0] INST_HALT    = 4'h0;
  localparam logic [OPC_W-1:0] INST_FORWARD = 4'h1;
  localparam logic [OPC_W-1:0] INST_NOP     = 4'h2;

  typedef struct packed {
    logic [OPC_W-1:0]        opcode;
    logic [XY_MEM_DEPTH-1:0] x_addr;
    logic [XY_MEM_DEPTH-1:0] y_addr;
    logic [W_MEM_DEPTH-1:0]  w_addr;
    logic [MOV_LENGTH-1:0]   length0;
    logic [MOV_LENGTH-1:0]   length1;
  } inst_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALTED
  } seq_state_t;

  typedef enum logic [1:0] {
    DEC_HALT, DEC_SKIP, DEC_ISSUE, DEC_ILLEGAL
  } dec_t;

  // FORWARD with zero total length does no work, so it is skipped like a NOP.
  function automatic dec_t decode(input inst_t w);
    dec_t d;
    case (w.opcode)
      INST_HALT:    d = DEC_HALT;
      INST_NOP:     d = DEC_SKIP;
      INST_FORWARD: d = ((w.length0 | w.length1) == '0) ? DEC_SKIP : DEC_ISSUE;
      default:      d = DEC_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/nn_inst_sequencer.sv
// Fetches, decodes and issues instruction words to the NN controller, one at a time,
// waiting for ctrl_done before fetching the next word.
module nn_inst_sequencer
  import nn_inst_sequencer_pkg::*;
#(
  // Field widths follow the package so the inst_t layout stays consistent.
  parameter int PC_W_P   = PC_W,
  parameter int INST_W_P = INST_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [PC_W_P-1:0]       start_pc,
  input  logic                    abort,
  output logic                    imem_rd_en,
  output logic [PC_W_P-1:0]       imem_addr,
  input  logic [INST_W_P-1:0]     imem_rdata,
  output logic                    issue_valid,
  input  logic                    ctrl_ready,
  input  logic                    ctrl_done,
  output logic [OPC_W-1:0]        instruction,
  output logic [MOV_LENGTH-1:0]   length0,
  output logic [MOV_LENGTH-1:0]   length1,
  output logic [XY_MEM_DEPTH-1:0] xy_read_addr,
  output logic [XY_MEM_DEPTH-1:0] xy_write_addr,
  output logic [W_MEM_DEPTH-1:0]  w_read_addr,
  output logic                    busy,
  output logic                    halted,
  output logic                    err_illegal
);

  seq_state_t        state, state_nxt;
  logic [PC_W_P-1:0] pc;
  inst_t             word;
  dec_t              dec;
  logic              start_ok;

  assign word     = inst_t'(imem_rdata);
  assign dec      = decode(word);
  assign start_ok = start && !abort && (state == S_IDLE || state == S_HALTED);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_rd_en  = 1'b0;
    issue_valid = 1'b0;
    busy        = 1'b1;
    halted      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_FETCH;
      end
      S_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_rd_en = 1'b1;
        state_nxt  = S_DECODE;
      end
      S_DECODE: begin
        case (dec)
          DEC_ISSUE: state_nxt = S_ISSUE;
          DEC_SKIP:  state_nxt = S_FETCH;
          default:   state_nxt = S_HALTED;
        endcase
      end
      S_ISSUE: begin
        issue_valid = 1'b1;
        if (ctrl_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (ctrl_done) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  assign imem_addr = pc;

  // Issued fields are latched once in DECODE and held through ISSUE and WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= '0;
      instruction   <= INST_HALT;
      length0       <= '0;
      length1       <= '0;
      xy_read_addr  <= '0;
      xy_write_addr <= '0;
      w_read_addr   <= '0;
      err_illegal   <= 1'b0;
    end else if (abort) begin
      pc            <= '0;
      instruction   <= INST_HALT;
      length0       <= '0;
      length1       <= '0;
      xy_read_addr  <= '0;
      xy_write_addr <= '0;
      w_read_addr   <= '0;
    end else begin
      if (start_ok) begin
        pc          <= start_pc;
        err_illegal <= 1'b0;
      end
      if (state == S_DECODE) begin
        instruction   <= word.opcode;
        length0       <= word.length0;
        length1       <= word.length1;
        xy_read_addr  <= word.x_addr;
        xy_write_addr <= word.y_addr;
        w_read_addr   <= word.w_addr;
        if (dec == DEC_ILLEGAL) err_illegal <= 1'b1;
        if (dec == DEC_SKIP)    pc <= pc + 1'b1;
      end
      if (state == S_WAIT && ctrl_done) pc <= pc + 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_inst_sequencer.sv
// Directed bench for nn_inst_sequencer with a registered instruction memory model.
module tb_nn_inst_sequencer;
  import nn_inst_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, ctrl_ready, ctrl_done;
  logic [7:0]  start_pc;
  logic        imem_rd_en, issue_valid, busy, halted, err_illegal;
  logic [7:0]  imem_addr;
  logic [45:0] imem_rdata;
  logic [3:0]  instruction;
  logic [7:0]  length0, length1, xy_read_addr, xy_write_addr;
  logic [9:0]  w_read_addr;

  logic [45:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;

  int          ncyc, n_issue, first_issue, done_cyc;
  int          addr_q[$];
  int          rdc_q[$];
  logic [3:0]  f_ins;
  logic [7:0]  f_x, f_y, f_l0, f_l1;
  logic [9:0]  f_w;

  nn_inst_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc), .abort(abort),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .ctrl_ready(ctrl_ready), .ctrl_done(ctrl_done),
    .instruction(instruction), .length0(length0), .length1(length1),
    .xy_read_addr(xy_read_addr), .xy_write_addr(xy_write_addr), .w_read_addr(w_read_addr),
    .busy(busy), .halted(halted), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
    if (issue_valid && ctrl_ready) acc_cnt <= acc_cnt + 1;
  end

  function automatic logic [45:0] mk(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                                     input logic [9:0] w, input logic [7:0] l0, input logic [7:0] l1);
    return {op, x, y, w, l0, l1};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = mk(INST_HALT, 8'd0, 8'd0, 10'd0, 8'd0, 8'd0);
  endtask

  // Starts a program (caller sits on a negedge) and plays an always-ready controller
  // that pulses ctrl_done dly cycles after each issue; stops on halted or maxc cycles.
  task automatic run_prog(input logic [7:0] spc, input int maxc, input int dly);
    int cnt;
    cnt = -1; ncyc = 0; n_issue = 0; first_issue = -1; done_cyc = -1;
    addr_q.delete(); rdc_q.delete();
    ctrl_ready = 1'b1; start_pc = spc; start = 1'b1;
    do begin
      @(negedge clk);
      ncyc++;
      start = 1'b0;
      ctrl_done = 1'b0;
      if (imem_rd_en) begin addr_q.push_back(int'(imem_addr)); rdc_q.push_back(ncyc); end
      if (issue_valid) begin
        if (n_issue == 0) begin
          first_issue = ncyc; f_ins = instruction; f_x = xy_read_addr; f_y = xy_write_addr;
          f_w = w_read_addr; f_l0 = length0; f_l1 = length1;
        end
        n_issue++;
        cnt = dly;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin ctrl_done = 1'b1; done_cyc = ncyc; end
      end
    end while (!halted && ncyc < maxc);
    ctrl_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; ctrl_ready = 1'b0; ctrl_done = 1'b0; start_pc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, halted, issue_valid, imem_rd_en, err_illegal} !== 5'b0 || instruction !== INST_HALT ||
        imem_addr !== 8'd0 || length0 !== 8'd0 || length1 !== 8'd0 || xy_read_addr !== 8'd0 ||
        xy_write_addr !== 8'd0 || w_read_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b halted=%b iv=%b rd=%b err=%b ins=%h addr=%0d",
               busy, halted, issue_valid, imem_rd_en, err_illegal, instruction, imem_addr);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward_halt();
    clear_mem();
    mem[0] = mk(INST_FORWARD, 8'd2, 8'd0, 10'd12, 8'd4, 8'd2);
    mem[1] = mk(INST_HALT, 8'd0, 8'd0, 10'd0, 8'd0, 8'd0);
    run_prog(8'd0, 40, 6);
    checks++;
    if (rdc_q.size() != 2 || rdc_q[0] != 1 || addr_q[0] != 0) begin
      errors++; $display("FAIL fwd_first_fetch: n=%0d cyc=%0d addr=%0d need 2/1/0",
                         rdc_q.size(), rdc_q.size() ? rdc_q[0] : -1, addr_q.size() ? addr_q[0] : -1);
    end
    checks++;
    if (first_issue != 3 || n_issue != 1) begin
      errors++; $display("FAIL fwd_issue_latency: cyc=%0d n=%0d need 3/1", first_issue, n_issue);
    end
    checks++;
    if (f_ins !== INST_FORWARD || f_x !== 8'd2 || f_y !== 8'd0 || f_w !== 10'd12 ||
        f_l0 !== 8'd4 || f_l1 !== 8'd2) begin
      errors++; $display("FAIL fwd_fields: %h %0d %0d %0d %0d %0d need 1 2 0 12 4 2",
                         f_ins, f_x, f_y, f_w, f_l0, f_l1);
    end
    checks++;
    if (done_cyc != 9 || rdc_q.size() != 2 || rdc_q[1] != 10 || addr_q[1] != 1) begin
      errors++; $display("FAIL fwd_done_to_fetch: done=%0d next=%0d need 9/10 addr 1",
                         done_cyc, rdc_q.size() > 1 ? rdc_q[1] : -1);
    end
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || imem_addr !== 8'd1 || err_illegal !== 1'b0) begin
      errors++; $display("FAIL fwd_halted: halted=%b busy=%b pc=%0d err=%b need 1/0/1/0",
                         halted, busy, imem_addr, err_illegal);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    logic [45:0] snap;
    bit stable;
    clear_mem();
    mem[0] = mk(INST_FORWARD, 8'd2, 8'd0, 10'd12, 8'd4, 8'd2);
    ctrl_ready = 1'b0; start_pc = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a0 = acc_cnt;
    snap = {instruction, xy_read_addr, xy_write_addr, w_read_addr, length0, length1};
    checks++;
    if (snap !== mk(INST_FORWARD, 8'd2, 8'd0, 10'd12, 8'd4, 8'd2)) begin
      errors++; $display("FAIL bp_fields: got %h need %h", snap, mk(INST_FORWARD, 8'd2, 8'd0, 10'd12, 8'd4, 8'd2));
    end
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (issue_valid !== 1'b1 ||
          {instruction, xy_read_addr, xy_write_addr, w_read_addr, length0, length1} !== snap)
        stable = 1'b0;
    end
    checks++;
    if (!stable || acc_cnt != a0) begin
      errors++; $display("FAIL bp_hold: stable=%0d accepts=%0d need 1/0", stable, acc_cnt - a0);
    end
    ctrl_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b0 || busy !== 1'b1 || acc_cnt - a0 != 1) begin
      errors++; $display("FAIL bp_accept: iv=%b busy=%b accepts=%0d need 0/1/1", issue_valid, busy, acc_cnt - a0);
    end
    ctrl_done = 1'b1;
    @(negedge clk); ctrl_done = 1'b0;
    for (int k = 0; k < 10 && !halted; k++) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || acc_cnt - a0 != 1 || imem_addr !== 8'd1) begin
      errors++; $display("FAIL bp_finish: halted=%b accepts=%0d pc=%0d need 1/1/1", halted, acc_cnt - a0, imem_addr);
    end
  endtask

  task automatic test_skip();
    clear_mem();
    mem[0] = mk(INST_FORWARD, 8'd5, 8'd6, 10'd7, 8'd0, 8'd0);
    mem[1] = mk(INST_NOP, 8'd1, 8'd1, 10'd1, 8'd1, 8'd1);
    mem[2] = mk(INST_HALT, 8'd0, 8'd0, 10'd0, 8'd0, 8'd0);
    run_prog(8'd0, 30, 2);
    checks++;
    if (n_issue != 0 || halted !== 1'b1 || imem_addr !== 8'd2 || addr_q.size() != 3 || ncyc != 7) begin
      errors++; $display("FAIL skip: issues=%0d halted=%b pc=%0d fetches=%0d cyc=%0d need 0/1/2/3/7",
                         n_issue, halted, imem_addr, addr_q.size(), ncyc);
    end
  endtask

  task automatic test_pc_wrap();
    clear_mem();
    mem[255] = mk(INST_FORWARD, 8'd9, 8'd8, 10'd1023, 8'd1, 8'd0);
    run_prog(8'd255, 30, 2);
    checks++;
    if (addr_q.size() != 2 || addr_q[0] != 255 || addr_q[1] != 0 || n_issue != 1) begin
      errors++; $display("FAIL wrap_addrs: n=%0d a0=%0d a1=%0d issues=%0d need 2/255/0/1", addr_q.size(),
                         addr_q.size() ? addr_q[0] : -1, addr_q.size() > 1 ? addr_q[1] : -1, n_issue);
    end
    checks++;
    if (halted !== 1'b1 || imem_addr !== 8'd0 || f_w !== 10'd1023) begin
      errors++; $display("FAIL wrap_halt: halted=%b pc=%0d w=%0d need 1/0/1023", halted, imem_addr, f_w);
    end
  endtask

  task automatic test_illegal();
    clear_mem();
    mem[0] = mk(4'hF, 8'd1, 8'd2, 10'd3, 8'd4, 8'd5);
    run_prog(8'd0, 30, 2);
    checks++;
    if (err_illegal !== 1'b1 || halted !== 1'b1 || n_issue != 0 || imem_addr !== 8'd0) begin
      errors++; $display("FAIL illegal: err=%b halted=%b issues=%0d pc=%0d need 1/1/0/0",
                         err_illegal, halted, n_issue, imem_addr);
    end
    mem[0] = mk(INST_HALT, 8'd0, 8'd0, 10'd0, 8'd0, 8'd0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (err_illegal !== 1'b0 || halted !== 1'b0 || imem_rd_en !== 1'b1) begin
      errors++; $display("FAIL illegal_clear: err=%b halted=%b rd=%b need 0/0/1", err_illegal, halted, imem_rd_en);
    end
    for (int k = 0; k < 10 && !halted; k++) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || err_illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_rerun: halted=%b err=%b need 1/0", halted, err_illegal);
    end
  endtask

  task automatic test_reset_abort();
    bit quiet;
    clear_mem();
    mem[0] = mk(INST_FORWARD, 8'd3, 8'd4, 10'd5, 8'd6, 8'd7);
    ctrl_ready = 1'b1; start_pc = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || issue_valid !== 1'b0 || length1 !== 8'd7) begin
      errors++; $display("FAIL wait_state: busy=%b iv=%b l1=%0d need 1/0/7", busy, issue_valid, length1);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, halted, issue_valid, imem_rd_en, err_illegal} !== 5'b0 || instruction !== INST_HALT ||
        imem_addr !== 8'd0 || length0 !== 8'd0 || length1 !== 8'd0 || xy_read_addr !== 8'd0 ||
        xy_write_addr !== 8'd0 || w_read_addr !== 10'd0) begin
      errors++; $display("FAIL async_reset: busy=%b iv=%b ins=%h pc=%0d l0=%0d", busy, issue_valid,
                         instruction, imem_addr, length0);
    end
    @(negedge clk); reset_n = 1'b1;
    ctrl_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (issue_valid !== 1'b1 || instruction !== INST_FORWARD) begin
      errors++; $display("FAIL rerun_issue: iv=%b ins=%h need 1/1", issue_valid, instruction);
    end
    abort = 1'b1; start = 1'b1; ctrl_ready = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    checks++;
    if (issue_valid !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 || imem_rd_en !== 1'b0 ||
        instruction !== INST_HALT) begin
      errors++; $display("FAIL abort: iv=%b busy=%b halted=%b rd=%b ins=%h need 0/0/0/0/0",
                         issue_valid, busy, halted, imem_rd_en, instruction);
    end
    quiet = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ctrl_done = 1'b1;
      @(negedge clk); ctrl_done = 1'b0;
      @(negedge clk);
      if (busy !== 1'b0 || imem_rd_en !== 1'b0 || issue_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL done_ignored: busy=%b rd=%b iv=%b need 0/0/0", busy, imem_rd_en, issue_valid);
    end
  endtask

  initial begin
    test_reset();
    test_forward_halt();
    test_backpressure();
    test_skip();
    test_pc_wrap();
    test_illegal();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
